// File: rtl/gcm_tag_verify_if.sv
// Signal bundle between a GCM core and the tag comparator.
// Tag bit 0 (first on the wire) is the vector MSB, bit [127].
interface gcm_tag_verify_if;
    logic [127:0] i_tag;
    logic         i_tag_ready;
    logic [127:0] i_expected_tag;
    logic         i_expected_valid;
    logic         i_abort;
    logic         o_busy;
    logic         o_done;
    logic         o_tag_ok;
    logic [2:0]   o_first_bad;

    modport master (
        output i_tag, i_tag_ready, i_expected_tag, i_expected_valid, i_abort,
        input  o_busy, o_done, o_tag_ok, o_first_bad
    );

    modport slave (
        input  i_tag, i_tag_ready, i_expected_tag, i_expected_valid, i_abort,
        output o_busy, o_done, o_tag_ok, o_first_bad
    );
endinterface

// File: rtl/gcm_tag_verify.sv
// Constant-time GCM tag comparator: one WORD_W slice per cycle over the leading
// TAG_LEN bits, sticky diff accumulation, verdict pulsed on o_done.
module gcm_tag_verify #(
    parameter int TAG_LEN = 128,
    parameter int WORD_W  = 16
) (
    input  logic            clk,
    input  logic            i_reset_n,
    gcm_tag_verify_if.slave bus
);

    localparam int NW    = TAG_LEN / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Reset asserts asynchronously but releases two edges later.
    logic rst_meta, rst_sync;
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    state_t             state, state_nxt;
    logic               have_tag, have_tag_nxt;
    logic               have_exp, have_exp_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [IDX_W-1:0]   bad_idx, bad_idx_nxt;
    logic [WORD_W-1:0]  diff, diff_nxt;
    logic               ok_q, ok_nxt;
    logic [2:0]         first_bad_q, first_bad_nxt;
    logic               busy_q;
    logic               cap_tag, cap_exp;
    logic [127:0]       tag_q, exp_q;
    logic [WORD_W-1:0]  word_xor;

    assign word_xor = tag_q[127 - int'(idx) * WORD_W -: WORD_W]
                    ^ exp_q[127 - int'(idx) * WORD_W -: WORD_W];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        have_tag_nxt  = have_tag;
        have_exp_nxt  = have_exp;
        idx_nxt       = idx;
        bad_idx_nxt   = bad_idx;
        diff_nxt      = diff;
        ok_nxt        = ok_q;
        first_bad_nxt = first_bad_q;
        cap_tag       = 1'b0;
        cap_exp       = 1'b0;

        if (bus.i_abort) begin
            state_nxt    = IDLE;
            have_tag_nxt = 1'b0;
            have_exp_nxt = 1'b0;
            idx_nxt      = '0;
            bad_idx_nxt  = '0;
            diff_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    cap_tag      = bus.i_tag_ready;
                    cap_exp      = bus.i_expected_valid;
                    have_tag_nxt = have_tag | bus.i_tag_ready;
                    have_exp_nxt = have_exp | bus.i_expected_valid;
                    if (have_tag_nxt && have_exp_nxt) begin
                        state_nxt = COMPARE;
                        idx_nxt   = '0;
                    end
                end
                COMPARE: begin
                    diff_nxt = diff | word_xor;
                    // An all-zero diff means no earlier word mismatched.
                    if (diff == '0 && word_xor != '0) bad_idx_nxt = idx;
                    if (idx == LAST) begin
                        state_nxt     = DONE;
                        ok_nxt        = (diff_nxt == '0);
                        first_bad_nxt = ok_nxt ? 3'd0 : 3'(bad_idx_nxt);
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state_nxt    = IDLE;
                    have_tag_nxt = 1'b0;
                    have_exp_nxt = 1'b0;
                    idx_nxt      = '0;
                    bad_idx_nxt  = '0;
                    diff_nxt     = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state       <= IDLE;
            have_tag    <= 1'b0;
            have_exp    <= 1'b0;
            idx         <= '0;
            bad_idx     <= '0;
            diff        <= '0;
            ok_q        <= 1'b0;
            first_bad_q <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            have_tag    <= have_tag_nxt;
            have_exp    <= have_exp_nxt;
            idx         <= idx_nxt;
            bad_idx     <= bad_idx_nxt;
            diff        <= diff_nxt;
            ok_q        <= ok_nxt;
            first_bad_q <= first_bad_nxt;
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // NOTE: tag storage has no reset; it is never read before a fresh capture.
    always_ff @(posedge clk) begin
        if (cap_tag) tag_q <= bus.i_tag;
        if (cap_exp) exp_q <= bus.i_expected_tag;
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = (state == DONE);
    assign bus.o_tag_ok    = ok_q;
    assign bus.o_first_bad = first_bad_q;

endmodule

// File: tb/tb_gcm_tag_verify.sv
// Randomized and directed bench for gcm_tag_verify at TAG_LEN 128 and 96,
// checked against a word-level reference model of the verdict and latency.
module tb_gcm_tag_verify;

    logic clk = 1'b0;
    logic i_reset_n;

    gcm_tag_verify_if a_if ();
    gcm_tag_verify_if b_if ();

    gcm_tag_verify #(.TAG_LEN(128), .WORD_W(16)) u_a (
        .clk(clk), .i_reset_n(i_reset_n), .bus(a_if.slave));
    gcm_tag_verify #(.TAG_LEN(96), .WORD_W(16)) u_b (
        .clk(clk), .i_reset_n(i_reset_n), .bus(b_if.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %0h expected %0h", tag, got, want);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Verdict from plain arithmetic: tag bit 0 is the MSB, words counted from the MSB end.
    function automatic void model(input logic [127:0] t, input logic [127:0] e, input int tl,
                                  output bit ok, output int bad);
        logic [127:0] x;
        x   = t ^ e;
        ok  = ((x >> (128 - tl)) == 128'd0);
        bad = 0;
        for (int w = tl / 16 - 1; w >= 0; w--)
            if (((x >> (112 - 16 * w)) & 128'hFFFF) != 128'd0) bad = w;
    endfunction

    task automatic drive_a(input bit ts, input logic [127:0] t, input bit es, input logic [127:0] e);
        a_if.i_tag_ready      = ts;
        a_if.i_tag            = t;
        a_if.i_expected_valid = es;
        a_if.i_expected_tag   = e;
    endtask

    task automatic no_done_a(input string nm, input int n);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            if (a_if.o_done || a_if.o_busy) seen = 1;
            tick();
        end
        check({nm, ".quiet"}, seen, 1'b0);
    endtask

    // Called in the first cycle after the completing strobe edge.
    task automatic wait_done_a(input string nm, input bit ok, input int bad,
                               input int inj, input logic [127:0] junk);
        int k = 1;
        bit busy_bad = 0;
        while (!a_if.o_done && k < 40) begin
            if (!a_if.o_busy) busy_bad = 1;
            a_if.i_tag_ready      = (k == inj);
            a_if.i_expected_valid = (k == inj);
            if (k == inj) a_if.i_tag = junk;
            tick();
            k++;
        end
        a_if.i_tag_ready      = 1'b0;
        a_if.i_expected_valid = 1'b0;
        if (!a_if.o_busy) busy_bad = 1;
        check({nm, ".latency"}, k, 9);
        check({nm, ".busy"}, busy_bad, 1'b0);
        check({nm, ".tag_ok"}, a_if.o_tag_ok, ok);
        check({nm, ".first_bad"}, a_if.o_first_bad, bad);
        tick();
        check({nm, ".done_drop"}, a_if.o_done, 1'b0);
        check({nm, ".busy_drop"}, a_if.o_busy, 1'b0);
    endtask

    task automatic run_a(input string nm, input logic [127:0] t, input logic [127:0] e,
                         input int gap, input bit tag_first, input bit dup);
        bit ok;
        int bad;
        bit idle_bad = 0;
        model(t, e, 128, ok, bad);
        if (dup) begin
            if (tag_first) drive_a(1, ~t, 0, e);
            else           drive_a(0, t, 1, ~e);
            tick();
            drive_a(0, t, 0, e);
        end
        if (gap == 0) begin
            drive_a(1, t, 1, e);
        end else begin
            if (tag_first) drive_a(1, t, 0, e);
            else           drive_a(0, t, 1, e);
            tick();
            drive_a(0, t, 0, e);
            for (int i = 1; i < gap; i++) begin
                if (a_if.o_busy) idle_bad = 1;
                tick();
            end
            if (tag_first) drive_a(0, t, 1, e);
            else           drive_a(1, t, 0, e);
        end
        if (a_if.o_busy) idle_bad = 1;
        tick();
        drive_a(0, t, 0, e);
        check({nm, ".idle_busy"}, idle_bad, 1'b0);
        wait_done_a(nm, ok, bad, 0, '0);
    endtask

    task automatic run_b(input string nm, input logic [127:0] t, input logic [127:0] e);
        bit ok;
        int bad;
        int k = 1;
        model(t, e, 96, ok, bad);
        b_if.i_tag = t;
        b_if.i_expected_tag = e;
        b_if.i_tag_ready = 1'b1;
        b_if.i_expected_valid = 1'b1;
        tick();
        b_if.i_tag_ready = 1'b0;
        b_if.i_expected_valid = 1'b0;
        while (!b_if.o_done && k < 40) begin
            tick();
            k++;
        end
        check({nm, ".latency"}, k, 7);
        check({nm, ".tag_ok"}, b_if.o_tag_ok, ok);
        check({nm, ".first_bad"}, b_if.o_first_bad, bad);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] t, e, m;
        int mode;

        i_reset_n = 1'b0;
        drive_a(0, '0, 0, '0);
        a_if.i_abort = 1'b0;
        b_if.i_tag = '0;
        b_if.i_expected_tag = '0;
        b_if.i_tag_ready = 1'b0;
        b_if.i_expected_valid = 1'b0;
        b_if.i_abort = 1'b0;
        repeat (3) tick();
        check("rst.busy", a_if.o_busy, 1'b0);
        check("rst.done", a_if.o_done, 1'b0);
        check("rst.tag_ok", a_if.o_tag_ok, 1'b0);
        check("rst.first_bad", a_if.o_first_bad, 3'd0);
        i_reset_n = 1'b1;
        repeat (4) tick();

        // Expected strobe at cycle 0, tag at cycle 5.
        run_a("match_gap5", PAT, PAT, 5, 0, 0);
        m = PAT;
        m[127 - 48] = ~m[127 - 48];
        m[127 - 96] = ~m[127 - 96];
        run_a("words3_6", m, PAT, 5, 0, 0);
        run_a("ones_same", '1, '1, 0, 0, 0);
        run_a("last_wins", PAT, PAT, 2, 1, 1);

        for (int i = 0; i < 24; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 2);
            if (mode == 0)      e = t;
            else if (mode == 1) e = t ^ (128'd1 << $urandom_range(0, 127));
            else                e = {$urandom, $urandom, $urandom, $urandom};
            run_a($sformatf("rnd%0d", i), t, e, $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort at COMPARE index 4 of a mismatching pair after an ok verdict.
        run_a("pre_abort", PAT, PAT, 0, 0, 0);
        m = PAT ^ (128'd1 << 100);
        drive_a(1, m, 1, PAT);
        tick();
        drive_a(0, m, 0, PAT);
        repeat (4) tick();
        check("abort.busy_before", a_if.o_busy, 1'b1);
        a_if.i_abort = 1'b1;
        tick();
        a_if.i_abort = 1'b0;
        check("abort.busy_after", a_if.o_busy, 1'b0);
        no_done_a("abort", 15);
        check("abort.tag_ok", a_if.o_tag_ok, 1'b1);
        check("abort.first_bad", a_if.o_first_bad, 3'd0);
        run_a("post_abort", m, PAT, 1, 1, 0);

        // Abort in IDLE with a simultaneous tag strobe clears the held expected tag.
        drive_a(0, PAT, 1, PAT);
        tick();
        drive_a(0, PAT, 0, PAT);
        tick();
        drive_a(1, PAT, 0, PAT);
        a_if.i_abort = 1'b1;
        tick();
        a_if.i_abort = 1'b0;
        drive_a(0, PAT, 0, PAT);
        no_done_a("idle_abort", 15);
        drive_a(1, PAT, 0, PAT);
        tick();
        drive_a(0, PAT, 0, PAT);
        no_done_a("tag_only", 12);
        drive_a(0, PAT, 1, PAT);
        tick();
        drive_a(0, PAT, 0, PAT);
        wait_done_a("late_exp", 1'b1, 0, 0, '0);

        // Strobes during COMPARE are ignored and never queued.
        drive_a(1, PAT, 1, PAT);
        tick();
        drive_a(0, PAT, 0, PAT);
        wait_done_a("ignore", 1'b1, 0, 3, PAT ^ {8{16'h8001}});
        no_done_a("no_queue", 15);

        // Reset for two cycles at COMPARE index 2.
        drive_a(1, PAT, 1, PAT);
        tick();
        drive_a(0, PAT, 0, PAT);
        repeat (2) tick();
        i_reset_n = 1'b0;
        #1;
        check("midrst.busy", a_if.o_busy, 1'b0);
        check("midrst.done", a_if.o_done, 1'b0);
        check("midrst.tag_ok", a_if.o_tag_ok, 1'b0);
        check("midrst.first_bad", a_if.o_first_bad, 3'd0);
        repeat (2) tick();
        i_reset_n = 1'b1;
        no_done_a("midrst", 20);
        run_a("post_rst", PAT, PAT ^ (128'd1 << 40), 0, 0, 0);

        // 96-bit instance: trailing 32 bits never matter.
        t = PAT;
        run_b("len96_tail", t, t ^ 128'hFFFF_FFFF);
        run_b("len96_word5", t, t ^ (128'd1 << 40));
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            run_b($sformatf("rnd96_%0d", i), t, t ^ (128'd1 << $urandom_range(0, 127)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
